// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD seven-segment scanner.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Scan position; value 3 is unreachable and treated as units.
  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_idx_t;

  // Pick the nibble of the packed BCD word belonging to a scan position.
  function automatic logic [3:0] nibble_of(input logic [11:0] bcd, input digit_idx_t idx);
    case (idx)
      DIG_TENS:     nibble_of = bcd[7:4];
      DIG_HUNDREDS: nibble_of = bcd[11:8];
      default:      nibble_of = bcd[3:0];
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high seven-segment pattern.
// Non-decimal nibbles (10..15) render as a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  // Pattern lookup
  always_comb begin
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Three-digit time-multiplexed seven-segment driver for a latched 12-bit
// packed BCD value. Each digit is lit for CLK_DIV cycles; non-decimal
// nibbles show a dash and raise bad_digit.
// Optional macro BCD_LZ_BLANK_EN: blank leading zeros on tens/hundreds
// (anode keeps scanning, only the segments go dark).
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] Bcd,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        bad_digit
);

  localparam int             PW  = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  TC  = PW'(CLK_DIV - 1);
  localparam logic           INV = (ACTIVE_LOW != 0);

  logic [11:0]           latch;
  logic [PW-1:0]         presc;
  digit_idx_t            idx;
  logic [3:0]            nib;
  logic [6:0]            pat;
  logic [6:0]            pat_b;
  logic [NUM_DIGITS-1:0] an_oh;
  logic                  bad_nxt;

  // Nibble selected by the current scan position feeds the shared decoder
  always_comb nib = nibble_of(latch, idx);

  seg7_decode u_dec (
    .nib (nib),
    .pat (pat)
  );

  // Leading-zero blanking (when enabled) and one-hot anode for current digit
  always_comb begin
    pat_b = pat;
`ifdef BCD_LZ_BLANK_EN
    if (idx == DIG_HUNDREDS && latch[11:8] == 4'd0)
      pat_b = 7'h00;
    else if (idx == DIG_TENS && latch[11:8] == 4'd0 && latch[7:4] == 4'd0)
      pat_b = 7'h00;
`endif
    case (idx)
      DIG_TENS:     an_oh = 3'b010;
      DIG_HUNDREDS: an_oh = 3'b100;
      default:      an_oh = 3'b001;
    endcase
    bad_nxt = (latch[11:8] > 4'd9) | (latch[7:4] > 4'd9) | (latch[3:0] > 4'd9);
  end

  // Latch, prescaler, scan index and registered outputs. Outputs are built
  // from pre-edge state so anode and segment always switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch     <= 12'h000;
      presc     <= '0;
      idx       <= DIG_UNITS;
      seg       <= {7{INV}};
      an        <= {3{INV}};
      bad_digit <= 1'b0;
    end else begin
      if (load)
        latch <= Bcd;
      if (presc == TC) begin
        presc <= '0;
        case (idx)
          DIG_UNITS: idx <= DIG_TENS;
          DIG_TENS:  idx <= DIG_HUNDREDS;
          default:   idx <= DIG_UNITS;
        endcase
      end else begin
        presc <= presc + 1'b1;
      end
      seg       <= pat_b ^ {7{INV}};
      an        <= an_oh ^ {3{INV}};
      bad_digit <= bad_nxt;
    end
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Downstream consumer of the BCD encoder stage: latches the 12-bit packed BCD result (hundreds/tens/units) of the multiplier datapath and drives a 3-digit time-multiplexed seven-segment display. A programmable prescaler sets how long each digit is lit. Nibbles above 9 are flagged and shown as a dash. Sits between the BCD encoder and the board display pins.

## Interface
- CLK_DIV, 50000, clock cycles each digit stays lit; legal range ≥2
- ACTIVE_LOW, 1, 1: `seg` and `an` are active-low (common anode); 0: active-high
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  reset; synchronous and active-high
- Bcd  input  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units
- load  input  1  when high at an edge, `Bcd` is captured into the display latch
- seg  output  7  segment drive, order {g,f,e,d,c,b,a}
- an  output  3  one-hot digit enable: an[0] units, an[1] tens, an[2] hundreds
- bad_digit  output  1  high while any latched nibble is >9

## Operation
- Latch: a 12-bit register, loaded from `Bcd` on any edge with load=1; otherwise holds its value.
- Prescaler: counter runs 0..CLK_DIV-1 and wraps to 0. At terminal count (CLK_DIV-1), the digit index advances.
- Digit index state: 0 (units) → 1 (tens) → 2 (hundreds) → 0. Each state dwells exactly CLK_DIV cycles.
- Decode (active-high values before polarity is applied):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - nibble 10..15 = 40 (dash)
- Polarity: when ACTIVE_LOW=1, both `seg` and the one-hot `an` are bitwise inverted.
- bad_digit: any latched nibble >9, registered.
- Simultaneous load and terminal count: both take effect on the same edge. The newly selected digit shows the newly latched value.
- load held high: the latch tracks `Bcd` every cycle; the scan is unaffected.

## Timing
- Reset values (edge with rst=1):
  - latch = 0, prescaler = 0, digit index = 0
  - seg = all segments off (7'h7F when ACTIVE_LOW=1, 7'h00 when 0)
  - an = all digits off (3'b111 when ACTIVE_LOW=1, 3'b000 when 0)
  - bad_digit = 0
- rst overrides load and the scan. Reset mid-scan has the same effect as reset at start.
- `seg`, `an` and `bad_digit` are registered, computed from the latch/index values before the edge. Consequences:
  - Load captured at edge N becomes visible on the outputs at edge N+1 (latency 1).
  - The first edge after rst deasserts drives digit 0.
- An index change at edge M appears on `an`/`seg` at edge M+1. The `an` and `seg` transitions are always simultaneous, so ghosting is avoided.

## Configuration
- BCD_LZ_BLANK_EN defined: leading-zero blanking.
  - Hundreds digit is blanked (segments off, `an` still scanned) when the hundreds nibble is 0.
  - Tens digit is blanked when both the hundreds and tens nibbles are 0.
  - Units is never blanked.
  - Invalid nibbles are never blanked.
- BCD_LZ_BLANK_EN undefined: every digit always shows its decoded pattern, including leading zeros.

## Structure
- Shared package `bcd_disp_pkg`:
  - segment pattern constants SEG_0..SEG_9 and SEG_DASH
  - NUM_DIGITS = 3
  - 2-bit digit-index typedef
- Sub-module `seg7_decode`: combinational, 4-bit nibble in → 7-bit active-high pattern out. Instantiated once, fed by the index-selected nibble. Polarity inversion and blanking stay in the parent.

## Test plan
- CLK_DIV=4, ACTIVE_LOW=0: reset, load 12'h255.
  - Edge+1: seg=6D, an=001 for 4 cycles.
  - Then seg=6D, an=010 for 4 cycles.
  - Then seg=5B, an=100.
  - Then wraps to units.
- Load 12'h007.
  - With BCD_LZ_BLANK_EN: units seg=07; tens and hundreds seg=00 while an still scans 010/100.
  - Without the macro: tens and hundreds seg=3F.
- Load 12'h1A3 → bad_digit=1 one edge later; tens slot shows seg=40. Then load 12'h123 → bad_digit returns to 0 one edge later.
- Assert load on the edge where the prescaler=3 in digit 0 → the tens slot immediately displays the new tens nibble.
- Assert rst during digit 1 → next edge: seg=00, an=000, bad_digit=0. After release, the scan restarts at units showing 3F with a full 4-cycle dwell.
- ACTIVE_LOW=1: load 12'h000 → units slot shows seg=7'h40, an=3'b110; reset values are seg=7'h7F, an=3'b111.
